// File: rtl/multi_fifo_read_arbiter.sv
// Round-robin read scheduler for fixed-latency FIFOs: bursts of up to BURST_LEN reads per source,
// tags every in-flight read, muxes returning data and flags return-protocol violations.
module multi_fifo_read_arbiter #(
  parameter int unsigned NUMBER_OF_FIFOS = 4,
  parameter int unsigned WIDTH           = 16,
  parameter int unsigned READ_LATENCY    = 4,
  parameter int unsigned BURST_LEN       = 4,
  parameter int unsigned INDEX_WIDTH     = $clog2(NUMBER_OF_FIFOS)
) (
  input  logic                                 clk,
  input  logic                                 rstN,
  input  logic [NUMBER_OF_FIFOS-1:0]           empties,
  output logic [NUMBER_OF_FIFOS-1:0]           readRequests,
  input  logic [NUMBER_OF_FIFOS-1:0]           dataOutValids,
  input  logic [WIDTH*NUMBER_OF_FIFOS-1:0]     dataIns,
  input  logic                                 slowDown,
  output logic [WIDTH-1:0]                     dataOut,
  output logic                                 dataOutValid,
  output logic [INDEX_WIDTH-1:0]               sourceIndex,
  output logic [$clog2(READ_LATENCY+1)-1:0]    readsInFlight,
  output logic                                 protocolError
);

  localparam int unsigned CntWidth = $clog2(READ_LATENCY + 1);

  typedef enum logic [0:0] {StBurst, StRotate} state_e;

  state_e                                  state_q, state_d;
  logic [INDEX_WIDTH-1:0]                  grant_q, grant_d;
  logic [7:0]                              burst_cnt_q, burst_cnt_d;
  logic [READ_LATENCY-1:0]                 tag_vld_q;
  logic [READ_LATENCY-1:0][INDEX_WIDTH-1:0] tag_idx_q;
  logic [CntWidth-1:0]                     inflight_q, inflight_d;
  logic [WIDTH-1:0]                        data_out_q;
  logic                                    data_out_vld_q;
  logic [INDEX_WIDTH-1:0]                  src_idx_q;
  logic                                    err_q;

  logic                                    issue;
  logic                                    found;
  logic [INDEX_WIDTH-1:0]                  cand;
  logic                                    any_valid, multi_valid;
  logic [INDEX_WIDTH-1:0]                  ret_idx;
  logic [WIDTH-1:0]                        ret_data;
  logic                                    tail_vld;
  logic [INDEX_WIDTH-1:0]                  tail_idx;
  logic                                    err_now;
  logic                                    inc, dec;

  // Gated by the live empty flag, so every strobe is an accepted read.
  assign issue = (state_q == StBurst) && !slowDown && !empties[grant_q] &&
                 (burst_cnt_q < 8'(BURST_LEN));

  assign readRequests = (rstN && issue) ?
                        (NUMBER_OF_FIFOS'(1) << grant_q) : '0;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    burst_cnt_d = burst_cnt_q;
    found       = 1'b0;
    cand        = '0;
    unique case (state_q)
      StBurst: begin
        if (issue) burst_cnt_d = burst_cnt_q + 8'd1;
        // Leave on the post-increment count so a rotation costs exactly one idle cycle.
        if (empties[grant_q] || (burst_cnt_d == 8'(BURST_LEN))) state_d = StRotate;
      end
      StRotate: begin
        burst_cnt_d = '0;
        for (int unsigned off = 1; off <= NUMBER_OF_FIFOS; off++) begin
          cand = INDEX_WIDTH'((32'(grant_q) + off) % NUMBER_OF_FIFOS);
          if (!found && !empties[cand]) begin
            found   = 1'b1;
            grant_d = cand;
          end
        end
        if (found) state_d = StBurst;
      end
      default: state_d = StBurst;
    endcase
  end

  always_comb begin
    ret_idx  = '0;
    ret_data = '0;
    for (int k = int'(NUMBER_OF_FIFOS) - 1; k >= 0; k--) begin
      if (dataOutValids[k]) begin
        ret_idx  = INDEX_WIDTH'(k);
        ret_data = dataIns[WIDTH*k +: WIDTH];
      end
    end
  end

  assign any_valid   = |dataOutValids;
  assign multi_valid = |(dataOutValids & (dataOutValids - NUMBER_OF_FIFOS'(1)));
  assign tail_vld    = tag_vld_q[READ_LATENCY-1];
  assign tail_idx    = tag_idx_q[READ_LATENCY-1];

  assign err_now = multi_valid ||
                   (any_valid && !tail_vld) ||
                   (any_valid && tail_vld && (ret_idx != tail_idx)) ||
                   (tail_vld && !any_valid);

  // Counter saturates both ways so stray returns cannot wrap it.
  always_comb begin
    dec        = any_valid && (inflight_q != '0);
    inc        = issue && ((inflight_q != CntWidth'(READ_LATENCY)) || dec);
    inflight_d = inflight_q;
    if (inc && !dec)      inflight_d = inflight_q + CntWidth'(1);
    else if (dec && !inc) inflight_d = inflight_q - CntWidth'(1);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q     <= StBurst;
      grant_q     <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      tag_vld_q <= '0;
      tag_idx_q <= '0;
    end else begin
      tag_vld_q[0] <= issue;
      tag_idx_q[0] <= grant_q;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_idx_q[i] <= tag_idx_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      data_out_q     <= '0;
      data_out_vld_q <= 1'b0;
      src_idx_q      <= '0;
      inflight_q     <= '0;
      err_q          <= 1'b0;
    end else begin
      data_out_vld_q <= any_valid;
      if (any_valid) begin
        data_out_q <= ret_data;
        src_idx_q  <= ret_idx;
      end
      inflight_q <= inflight_d;
      if (err_now) err_q <= 1'b1;
    end
  end

  assign dataOut       = data_out_q;
  assign dataOutValid  = data_out_vld_q;
  assign sourceIndex   = src_idx_q;
  assign readsInFlight = inflight_q;
  assign protocolError = err_q;

endmodule

// File: tb/tb_multi_fifo_read_arbiter.sv
// Bench for multi_fifo_read_arbiter: behavioural FIFOs with fixed read latency feed a
// scoreboard of {source, word} pairs; arbitration order and timing are checked against constants.
module tb_multi_fifo_read_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 16;
  localparam int unsigned L  = 4;
  localparam int unsigned B  = 4;
  localparam int unsigned IW = 2;
  localparam int unsigned CW = 3;

  logic              clk = 1'b0;
  logic              rstN;
  logic [N-1:0]      empties;
  logic [N-1:0]      readRequests;
  logic [N-1:0]      dataOutValids;
  logic [W*N-1:0]    dataIns;
  logic              slowDown;
  logic [W-1:0]      dataOut;
  logic              dataOutValid;
  logic [IW-1:0]     sourceIndex;
  logic [CW-1:0]     readsInFlight;
  logic              protocolError;

  always #5 clk = ~clk;

  multi_fifo_read_arbiter #(
    .NUMBER_OF_FIFOS(N),
    .WIDTH          (W),
    .READ_LATENCY   (L),
    .BURST_LEN      (B),
    .INDEX_WIDTH    (IW)
  ) dut (
    .clk          (clk),
    .rstN         (rstN),
    .empties      (empties),
    .readRequests (readRequests),
    .dataOutValids(dataOutValids),
    .dataIns      (dataIns),
    .slowDown     (slowDown),
    .dataOut      (dataOut),
    .dataOutValid (dataOutValid),
    .sourceIndex  (sourceIndex),
    .readsInFlight(readsInFlight),
    .protocolError(protocolError)
  );

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  logic [W-1:0]    fifo [N][$];
  logic [W+IW-1:0] exp_q [$];
  logic            pv [L];
  logic [IW-1:0]   pi [L];
  logic [W-1:0]    pd [L];
  logic [N-1:0]    inj;
  logic            sb_off;
  logic [N-1:0]    rr_last;
  int              issue_log [$];
  int              out_idx_log [$];
  int              last_out_cyc;
  int              peak_if;
  int              dv_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < int'(N); i++) begin
      empties[i] = (fifo[i].size() == 0);
      dataIns[W*i +: W] = (pv[L-1] && (pi[L-1] == IW'(i))) ? pd[L-1] : W'(32'hBAD0 + i);
    end
    dataOutValids = inj;
    if (pv[L-1]) dataOutValids[pi[L-1]] = 1'b1;
  endtask

  // One clock: sample strobes mid-cycle, then advance the FIFO model and check outputs.
  task automatic tick();
    logic [N-1:0] rr;
    int nif;
    @(negedge clk);
    rr = readRequests;
    rr_last = rr;
    check_eq("rr_onehot0", 32'($onehot0(rr)), 32'd1);
    if (rr != '0) issue_log.push_back(cyc);
    @(posedge clk);
    #1;
    cyc++;
    for (int s = int'(L) - 1; s > 0; s--) begin
      pv[s] = pv[s-1];
      pi[s] = pi[s-1];
      pd[s] = pd[s-1];
    end
    pv[0] = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (rr[i]) begin
        check_eq("read_nonempty", 32'(fifo[i].size() != 0), 32'd1);
        if (fifo[i].size() != 0) begin
          pv[0] = 1'b1;
          pi[0] = IW'(i);
          pd[0] = fifo[i].pop_front();
          exp_q.push_back({IW'(i), pd[0]});
        end
      end
    end
    drive();
    nif = 0;
    for (int s = 0; s < int'(L); s++) if (pv[s]) nif++;
    if (!sb_off) begin
      check_eq("inflight", 32'(readsInFlight), 32'(nif));
      if (int'(readsInFlight) > peak_if) peak_if = int'(readsInFlight);
      if (dataOutValid) begin
        out_idx_log.push_back(int'(sourceIndex));
        last_out_cyc = cyc;
        dv_cnt++;
        check_eq("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check_eq("sb_word", 32'({sourceIndex, dataOut}),
                                        32'(exp_q.pop_front()));
      end
    end
  endtask

  function automatic bit fifos_empty();
    for (int i = 0; i < int'(N); i++) if (fifo[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !fifos_empty()) && n < 100) begin
      tick();
      n++;
    end
    check_eq("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic load(input int src, input int cnt);
    for (int j = 0; j < cnt; j++) fifo[src].push_back(W'(32'h1000 * (src + 1) + 32'(j)));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rr"},   32'(readRequests),  32'd0);
    check_eq({tag, "_dout"}, 32'(dataOut),       32'd0);
    check_eq({tag, "_dv"},   32'(dataOutValid),  32'd0);
    check_eq({tag, "_idx"},  32'(sourceIndex),   32'd0);
    check_eq({tag, "_rif"},  32'(readsInFlight), 32'd0);
    check_eq({tag, "_err"},  32'(protocolError), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int offs1 [10] = '{0, 1, 2, 3, 5, 6, 7, 8, 10, 11};
    int seq2 [15]  = '{1, 1, 1, 1, 2, 2, 2, 2, 0, 0, 0, 0, 1, 2, 0};
    int seq6 [4]   = '{0, 0, 2, 2};
    int nreads;
    int iss;

    rstN = 1'b0; slowDown = 1'b0; inj = '0; sb_off = 1'b0;
    peak_if = 0; dv_cnt = 0; last_out_cyc = 0;
    for (int s = 0; s < int'(L); s++) begin pv[s] = 1'b0; pi[s] = '0; pd[s] = '0; end

    // Single source, 10 words: strobes held off while in reset.
    load(0, 10);
    drive();
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rstN = 1'b1;
    cyc = 0;
    issue_log.delete();
    out_idx_log.delete();
    drain();
    check_eq("t1_issues", 32'(issue_log.size()), 32'd10);
    for (int j = 0; j < 10 && j < issue_log.size(); j++)
      check_eq($sformatf("t1_issue_off%0d", j), 32'(issue_log[j] - issue_log[0]), 32'(offs1[j]));
    check_eq("t1_outs", 32'(out_idx_log.size()), 32'd10);
    check_eq("t1_peak_inflight", 32'(peak_if), 32'd4);
    check_eq("t1_err", 32'(protocolError), 32'd0);

    // Three sources, rotation starts after the previous grant (0) and wraps past empty 3.
    out_idx_log.delete();
    load(0, 5); load(1, 5); load(2, 5);
    drive();
    drain();
    check_eq("t2_outs", 32'(out_idx_log.size()), 32'd15);
    for (int j = 0; j < 15 && j < out_idx_log.size(); j++)
      check_eq($sformatf("t2_seq%0d", j), 32'(out_idx_log[j]), 32'(seq2[j]));
    check_eq("t2_err", 32'(protocolError), 32'd0);

    // slowDown mid-burst on source 1.
    load(1, 8);
    drive();
    nreads = 0;
    for (int k = 0; k < 10 && nreads < 2; k++) begin
      tick();
      if (rr_last == 4'b0010) nreads++;
    end
    check_eq("t3_start", 32'(nreads), 32'd2);
    slowDown = 1'b1;
    dv_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq($sformatf("t3_slow_rr%0d", k), 32'(rr_last), 32'd0);
    end
    slowDown = 1'b0;
    check_eq("t3_inflight_emerged", 32'(dv_cnt > 0), 32'd1);
    tick(); check_eq("t3_resume0", 32'(rr_last), 32'b0010);
    tick(); check_eq("t3_resume1", 32'(rr_last), 32'b0010);
    tick(); check_eq("t3_rotate",  32'(rr_last), 32'b0000);
    tick(); check_eq("t3_reburst", 32'(rr_last), 32'b0010);
    drain();

    // All empty, then a single word on source 3.
    nreads = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (rr_last != '0) nreads++;
    end
    check_eq("t4_idle_reads", 32'(nreads), 32'd0);
    load(3, 1);
    drive();
    tick(); check_eq("t4_rotate_cycle", 32'(rr_last), 32'b0000);
    tick(); check_eq("t4_read3", 32'(rr_last), 32'b1000);
    iss = cyc - 1;
    out_idx_log.delete();
    drain();
    check_eq("t4_latency", 32'(last_out_cyc - iss), 32'(L + 1));
    check_eq("t4_idx", 32'(out_idx_log.size() == 1 ? out_idx_log[0] : -1), 32'd3);

    // Two valids at once raise a sticky error.
    sb_off = 1'b1;
    inj = 4'b0011;
    drive();
    tick();
    check_eq("t5_err_set", 32'(protocolError), 32'd1);
    inj = '0;
    drive();
    for (int k = 0; k < 3; k++) tick();
    check_eq("t5_err_sticky", 32'(protocolError), 32'd1);
    rstN = 1'b0;
    #1;
    check_eq("t5_err_cleared", 32'(protocolError), 32'd0);
    @(posedge clk); #1;
    rstN = 1'b1;
    sb_off = 1'b0;

    // Reset mid-burst: asynchronous clear, then restart from source 0.
    load(2, 8);
    drive();
    dv_cnt = 0;
    for (int k = 0; k < 20 && dv_cnt < 2; k++) tick();
    check_eq("t6_running", 32'(dv_cnt >= 2), 32'd1);
    #2;
    rstN = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    for (int i = 0; i < int'(N); i++) fifo[i].delete();
    exp_q.delete();
    for (int s = 0; s < int'(L); s++) pv[s] = 1'b0;
    out_idx_log.delete();
    load(0, 2); load(2, 2);
    drive();
    @(posedge clk); #1;
    check_eq("t6_rr_in_reset", 32'(readRequests), 32'd0);
    @(posedge clk); #1;
    rstN = 1'b1;
    drain();
    check_eq("t6_outs", 32'(out_idx_log.size()), 32'd4);
    for (int j = 0; j < 4 && j < out_idx_log.size(); j++)
      check_eq($sformatf("t6_seq%0d", j), 32'(out_idx_log[j]), 32'(seq6[j]));
    check_eq("t6_err", 32'(protocolError), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
